// File: rtl/constants_pkg.sv
// constants_pkg: shared widths, arbiter defaults and the grant-lock state type.
//   ADDR_WIDTH / DATA_WIDTH   : SRAM address and data widths
//   ARB_NUM_REQ / ARB_MAX_OUTST : default requester count and read depth
//   arb_state_e               : grant lock state (idle / locked on a stalled grant)
package constants_pkg;
  localparam int ADDR_WIDTH    = 16;
  localparam int DATA_WIDTH    = 32;
  localparam int ARB_NUM_REQ   = 2;
  localparam int ARB_MAX_OUTST = 4;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order FIFO of granted requester indices for in-flight reads.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_push / i_din    : push a tag (ignored when full, even if popping this cycle)
//   i_pop / o_dout    : pop the head tag (ignored when empty); o_dout is the head
//   o_full / o_empty  : occupancy flags
module arb_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;

  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one in-order SRAM read port among NUM_REQ requesters.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   r_req_vld/r_req_rdy/r_req_addr     : per-requester read request channels
//   r_rsp_vld/r_rsp_rdy/r_rsp_data     : per-requester response channels (data broadcast)
//   m_req_vld/m_req_rdy/m_req_addr     : SRAM request channel
//   m_rsp_vld/m_rsp_rdy/m_rsp_data     : SRAM in-order response channel
//   busy                               : reads in flight or a request presented
// Build option MEM_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module mem_arbiter import constants_pkg::*; #(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int MAX_OUTST = ARB_MAX_OUTST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            r_req_vld,
  output logic [NUM_REQ-1:0]            r_req_rdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] r_req_addr,
  output logic [NUM_REQ-1:0]            r_rsp_vld,
  input  logic [NUM_REQ-1:0]            r_rsp_rdy,
  output logic [DATA_WIDTH-1:0]         r_rsp_data,
  output logic                          m_req_vld,
  input  logic                          m_req_rdy,
  output logic [ADDR_WIDTH-1:0]         m_req_addr,
  input  logic                          m_rsp_vld,
  output logic                          m_rsp_rdy,
  input  logic [DATA_WIDTH-1:0]         m_rsp_data,
  output logic                          busy
);
  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e r_state, w_state_nxt;
  logic [TW-1:0] r_lock_gnt, w_lock_nxt, w_arb_gnt, w_gnt, w_head;
  logic w_full, w_empty, w_push, w_pop, w_locked;

  // a stalled grant stays put as long as its owner keeps requesting
  assign w_locked   = (r_state == ARB_LOCKED) && r_req_vld[r_lock_gnt];
  assign w_gnt      = w_locked ? r_lock_gnt : w_arb_gnt;
  // rst_n gating keeps the request side quiet while reset is held
  assign m_req_vld  = rst_n && (|r_req_vld) && !w_full;
  assign m_req_addr = r_req_addr[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
  assign r_req_rdy  = (m_req_vld && m_req_rdy) ? NUM_REQ'(1) << w_gnt : '0;
  assign w_push     = m_req_vld && m_req_rdy;
  assign m_rsp_rdy  = !w_empty && r_rsp_rdy[w_head];
  assign r_rsp_vld  = (!w_empty && m_rsp_vld) ? NUM_REQ'(1) << w_head : '0;
  assign w_pop      = m_rsp_vld && m_rsp_rdy;
  assign r_rsp_data = m_rsp_data;
  assign busy       = !w_empty || m_req_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_lock_gnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_gnt <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ARB_IDLE;
    w_lock_nxt  = r_lock_gnt;
    if (m_req_vld && !m_req_rdy) begin
      w_state_nxt = ARB_LOCKED;
      w_lock_nxt  = w_gnt;
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_arb_gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (r_req_vld[k]) w_arb_gnt = TW'(k);
  end
`else
  localparam logic [TW:0] NR = (TW+1)'(NUM_REQ);

  logic [TW-1:0] r_rr_ptr, w_off;
  logic [NUM_REQ-1:0] w_rot;
  logic [TW:0] w_sum;

  // rotate so bit 0 is the requester at rr_ptr, pick the first set bit, rotate back
  assign w_rot     = NUM_REQ'({r_req_vld, r_req_vld} >> r_rr_ptr);
  assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_arb_gnt = (w_sum >= NR) ? TW'(w_sum - NR) : TW'(w_sum);

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_off = TW'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rr_ptr <= '0;
    else if (w_push) r_rr_ptr <= (w_gnt == TW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
  end
`endif

  arb_tag_fifo #(.W(TW), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_gnt),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mem_arbiter;
  import constants_pkg::*;
  localparam int N = ARB_NUM_REQ;
  localparam int M = ARB_MAX_OUTST;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] r_req_vld, r_req_rdy, r_rsp_vld, r_rsp_rdy;
  logic [N*ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_rsp_data, m_rsp_data;
  logic m_req_vld, m_req_rdy, m_rsp_vld, m_rsp_rdy, busy;
  logic [ADDR_WIDTH-1:0] m_req_addr;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_req_vld  (r_req_vld),
    .r_req_rdy  (r_req_rdy),
    .r_req_addr (r_req_addr),
    .r_rsp_vld  (r_rsp_vld),
    .r_rsp_rdy  (r_rsp_rdy),
    .r_rsp_data (r_rsp_data),
    .m_req_vld  (m_req_vld),
    .m_req_rdy  (m_req_rdy),
    .m_req_addr (m_req_addr),
    .m_rsp_vld  (m_rsp_vld),
    .m_rsp_rdy  (m_rsp_rdy),
    .m_rsp_data (m_rsp_data),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // reference model: outstanding tags in issue order, round-robin start, held grant
  int q[$];
  int rr, lock, last_push_g;
  bit last_pop;
  logic [N-1:0] seen_rdy, seen_rsp;
  logic seen_mvld, seen_mrsprdy;
  logic [ADDR_WIDTH-1:0] seen_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    rr = 0;
    lock = -1;
    last_push_g = -1;
    last_pop = 1'b0;
  endfunction

  function automatic int pick();
    int g = -1;
    if (lock >= 0 && r_req_vld[lock]) return lock;
    for (int k = 0; k < N; k++) begin
      int i = FIXED ? k : (rr + k) % N;
      if (r_req_vld[i] && g < 0) g = i;
    end
    return g;
  endfunction

  function automatic logic [N-1:0] alt(input int k);
    return FIXED ? N'(1) : ((k % 2) != 0 ? N'(2) : N'(1));
  endfunction

  // check one cycle at the falling edge, then advance the model over the rising edge
  task automatic step();
    int g, h;
    bit full, emp, mv, pop, push;
    logic [N-1:0] erq, ersp;
    @(negedge clk);
    g = pick();
    full = q.size() == M;
    emp = q.size() == 0;
    mv = (g >= 0) && !full;
    h = emp ? 0 : q[0];
    erq = (mv && m_req_rdy) ? N'(1) << g : N'(0);
    ersp = (!emp && m_rsp_vld) ? N'(1) << h : N'(0);
    chk("m_req_vld", m_req_vld, mv);
    if (mv) chk("m_req_addr", m_req_addr, r_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]);
    if (g >= 0) chk("r_req_rdy", r_req_rdy, erq);
    chk("r_rsp_vld", r_rsp_vld, ersp);
    chk("m_rsp_rdy", m_rsp_rdy, !emp && r_rsp_rdy[h]);
    chk("r_rsp_data", r_rsp_data, m_rsp_data);
    chk("busy", busy, !emp || mv);
    seen_rdy = r_req_rdy;
    seen_rsp = r_rsp_vld;
    seen_mvld = m_req_vld;
    seen_mrsprdy = m_rsp_rdy;
    seen_addr = m_req_addr;
    pop = !emp && r_rsp_rdy[h] && m_rsp_vld;
    push = mv && m_req_rdy;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(g);
      rr = (g + 1) % N;
      lock = -1;
    end else lock = mv ? g : -1;
    last_push_g = push ? g : -1;
    last_pop = pop;
    #1;
  endtask

  // sources hold valid and payload until their transfer completes
  task automatic rand_inputs();
    for (int i = 0; i < N; i++)
      if (!r_req_vld[i] || last_push_g == i) begin
        r_req_vld[i] = 1'($urandom % 2);
        r_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'($urandom);
      end
    m_req_rdy = ($urandom % 4) != 0;
    if (!m_rsp_vld || last_pop) begin
      m_rsp_vld = 1'($urandom % 2);
      m_rsp_data = $urandom;
    end
    r_rsp_rdy = N'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_req_vld"}, m_req_vld, 1'b0);
    chk({tag, "_r_req_rdy"}, r_req_rdy, '0);
    chk({tag, "_r_rsp_vld"}, r_rsp_vld, '0);
    chk({tag, "_m_rsp_rdy"}, m_rsp_rdy, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    r_req_vld = '1;
    r_req_addr = '0;
    r_req_addr[0 +: ADDR_WIDTH] = ADDR_WIDTH'('h10);
    r_req_addr[ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'('h20);
    r_rsp_rdy = '1;
    m_req_rdy = 1'b1;
    m_rsp_vld = 1'b1;
    m_rsp_data = 32'hA5A5_0001;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_rsp_vld = 1'b0;
    // two requesters always valid: alternating grants until the FIFO fills
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_grant", seen_rdy, alt(k));
    end
    step();
    chk("full_blocks_req", seen_mvld, 1'b0);
    m_rsp_vld = 1'b1;
    m_rsp_data = 32'h1234_5678;
    step();
    chk("full_pop_rsp", seen_rsp, alt(0));
    chk("full_no_bypass", seen_mvld, 1'b0);
    m_rsp_vld = 1'b0;
    step();
    chk("after_pop_req", seen_mvld, 1'b1);
    chk("after_pop_grant", seen_rdy, alt(0));
    r_req_vld = '0;
    m_rsp_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_rsp_data = $urandom;
      step();
      chk("rsp_route", seen_rsp, alt(k + 1));
    end
    step();
    chk("stray_rsp_vld", seen_rsp, '0);
    chk("stray_rsp_rdy", seen_mrsprdy, 1'b0);
    // stalled grant to requester 0 survives requester 1 arriving
    m_rsp_vld = 1'b0;
    m_req_rdy = 1'b0;
    r_req_vld = N'(1);
    step();
    chk("lock_addr0", seen_addr, ADDR_WIDTH'('h10));
    r_req_vld = N'(3);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("lock_addr", seen_addr, ADDR_WIDTH'('h10));
    end
    m_req_rdy = 1'b1;
    step();
    chk("lock_xfer_addr", seen_addr, ADDR_WIDTH'('h10));
    chk("lock_xfer_rdy", seen_rdy, N'(1));
    step();
    chk("post_lock_grant", seen_rdy, alt(1));
    // reset with two reads outstanding
    m_rsp_vld = 1'b1;
    r_rsp_rdy = '1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_first_grant", seen_rdy, N'(1));
    chk("rst_rsp_dropped", seen_rsp, '0);
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the SRAM port (2..8).
REQ-002 Parameter MAX_OUTST, default 4: maximum in-flight reads; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 r_req_vld  input  NUM_REQ  per-requester read request valid.
REQ-006 r_req_rdy  output  NUM_REQ  per-requester request accepted.
REQ-007 r_req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 r_rsp_vld  output  NUM_REQ  per-requester response valid.
REQ-009 r_rsp_rdy  input  NUM_REQ  per-requester response ready.
REQ-010 r_rsp_data  output  DATA_WIDTH  response data, broadcast to all requesters.
REQ-011 m_req_vld / m_req_rdy / m_req_addr  output / input / output  1 / 1 / ADDR_WIDTH  SRAM request channel.
REQ-012 m_rsp_vld / m_rsp_rdy / m_rsp_data  input / output / input  1 / 1 / DATA_WIDTH  SRAM response channel; in-order responses.
REQ-013 busy  output  1  high while any read is in flight or m_req_vld is high.

Function
REQ-014 Handshake on every channel: transfer when vld and rdy are both high on a rising edge; a source holds vld and payload until transfer.
REQ-015 Default arbitration is round-robin: search starts at rr_ptr and wraps modulo NUM_REQ; the first requester with r_req_vld high is granted.
REQ-016 m_req_vld = (any r_req_vld) and tag FIFO not full; m_req_addr = granted requester's address; zero-cycle combinational path, no added latency.
REQ-017 r_req_rdy[g] = m_req_rdy and FIFO not full, for the granted g only; all other bits 0.
REQ-018 Grant lock: while m_req_vld is high and m_req_rdy is low, the grant is registered and held; a newly raised higher-priority request does not steal it.
REQ-019 On request transfer: push grant index into the tag FIFO; rr_ptr <= (g+1) mod NUM_REQ; clear the lock.
REQ-020 Responses route to FIFO head h: r_rsp_vld[h] = m_rsp_vld and FIFO not empty; other bits 0; r_rsp_data = m_rsp_data.
REQ-021 m_rsp_rdy = r_rsp_rdy[h] and FIFO not empty; pop the head on response transfer.
REQ-022 FIFO full: m_req_vld forced low and all r_req_rdy low; a pop in the same cycle does not enable a push (no full-bypass).
REQ-023 FIFO empty: m_rsp_rdy held low and all r_rsp_vld low; a stray m_rsp_vld is not accepted.
REQ-024 Simultaneous push and pop with FIFO neither full nor empty: count unchanged; both pointers advance with wrap at MAX_OUTST.
REQ-025 busy = (count != 0) or m_req_vld.

Reset
REQ-026 On rst_n low, immediately: rr_ptr = 0, lock cleared, FIFO empty (count 0, pointers 0); m_req_vld, r_req_rdy, r_rsp_vld, m_rsp_rdy, busy all 0.
REQ-027 Reset mid-transaction discards in-flight tags; responses arriving after reset are not accepted (REQ-023).

Configuration
REQ-028 Macro MEM_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins) and rr_ptr is not implemented; when undefined, round-robin per REQ-015. REQ-018 applies in both modes.

Structure
REQ-029 constants_pkg gains ARB_NUM_REQ (2) and ARB_MAX_OUTST (4) as defaults; ADDR_WIDTH and DATA_WIDTH come from constants_pkg.
REQ-030 One sub-module, arb_tag_fifo: width $clog2(NUM_REQ), depth MAX_OUTST, with full/empty flags, asynchronous active-low reset.

Verification
REQ-031 Requesters 0 and 1 both valid continuously, m_req_rdy=1 -> grants alternate 0,1,0,1; responses route to r_rsp_vld[0],[1],[0],[1] in order.
REQ-032 Requester 0 valid with addr 0x10, m_req_rdy=0 for 3 cycles; requester 1 raised in cycle 1 -> m_req_addr stays 0x10 until transfer, then requester 1 granted.
REQ-033 Four requests issued, no responses (MAX_OUTST=4) -> m_req_vld=0 on the fifth; one response popped -> next request accepted the following cycle.
REQ-034 m_rsp_vld=1 with FIFO empty -> m_rsp_rdy=0 and all r_rsp_vld=0.
REQ-035 rst_n asserted with 2 reads outstanding -> busy=0 and all outputs 0 immediately; after release, first grant goes to requester 0.
REQ-036 With MEM_ARB_FIXED_PRIO_EN, both requesters continuously valid -> requester 0 granted every cycle; requester 1 never granted.
